seq_muldiv_unit: RTL and testbench

- Parametrised multi-cycle arithmetic unit for the processor datapath: signed (radix-2 Booth) multiply, unsigned shift-add multiply, and unsigned restoring divide.
- Controller and datapath are integrated in one block, with a start/busy/done handshake.
- Replaces the fixed-width, multiply-only sequencing with one iteration per cycle, any operand width, a divide mode, and error flags.

---
 rtl/seq_muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_seq_muldiv_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seq_muldiv_unit.sv
// Multi-cycle arithmetic unit: signed Booth multiply, unsigned shift-add multiply
// and unsigned restoring divide, one iteration per clock, start/busy/done handshake.
module seq_muldiv_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero,
   output logic             illegal_op
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   m;
   logic [WIDTH:0]   acc_nxt;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_nxt;
   logic             q_1;
   logic             q1_nxt;
   logic [1:0]       op_r;
   logic [CW-1:0]    cnt;
   logic             err_req;

   assign err_req = (op == 2'b11) || ((op == 2'b10) && (b == '0));
   assign busy    = (state == CALC);
   assign done    = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = err_req ? DONE : CALC;
         CALC:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One iteration of the selected algorithm; acc holds A (multiply) or R (divide).
   always_comb begin
      sum     = acc;
      acc_nxt = acc;
      q_nxt   = q;
      q1_nxt  = q_1;
      case (op_r)
         2'b00: begin
            case ({q[0], q_1})
               2'b10:   sum = acc - m;
               2'b01:   sum = acc + m;
               default: sum = acc;
            endcase
            acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
            q_nxt   = {sum[0], q[WIDTH-1:1]};
            q1_nxt  = q[0];
         end
         2'b01: begin
            sum     = q[0] ? ({1'b0, acc[WIDTH-1:0]} + {1'b0, m[WIDTH-1:0]})
                           : {1'b0, acc[WIDTH-1:0]};
            acc_nxt = {1'b0, sum[WIDTH:1]};
            q_nxt   = {sum[0], q[WIDTH-1:1]};
         end
         default: begin
            sum     = {acc[WIDTH-1:0], q[WIDTH-1]} - m;
            q_nxt   = {q[WIDTH-2:0], ~sum[WIDTH]};
            acc_nxt = sum[WIDTH] ? {acc[WIDTH-1:0], q[WIDTH-1]} : sum;
         end
      endcase
   end

   // Error requests complete straight from IDLE; normal ones publish on the last CALC edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         m           <= '0;
         q           <= '0;
         q_1         <= 1'b0;
         op_r        <= 2'b00;
         cnt         <= '0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
         illegal_op  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r <= op;
                  acc  <= '0;
                  q_1  <= 1'b0;
                  cnt  <= CW'(WIDTH - 1);
                  case (op)
                     2'b00:   begin m <= {a[WIDTH-1], a}; q <= b; end
                     2'b01:   begin m <= {1'b0, a};       q <= b; end
                     default: begin m <= {1'b0, b};       q <= a; end
                  endcase
                  if (op == 2'b11) begin
                     result_hi   <= '0;
                     result_lo   <= '0;
                     div_by_zero <= 1'b0;
                     illegal_op  <= 1'b1;
                  end else if (err_req) begin
                     result_hi   <= a;
                     result_lo   <= '1;
                     div_by_zero <= 1'b1;
                     illegal_op  <= 1'b0;
                  end
               end
            end
            CALC: begin
               acc <= acc_nxt;
               q   <= q_nxt;
               q_1 <= q1_nxt;
               if (cnt == '0) begin
                  result_hi   <= acc_nxt[WIDTH-1:0];
                  result_lo   <= q_nxt;
                  div_by_zero <= 1'b0;
                  illegal_op  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed self-checking bench for seq_muldiv_unit at WIDTH=8.
module tb_seq_muldiv_unit;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [1:0]       op = 2'b00;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;
   logic             div_by_zero;
   logic             illegal_op;

   int tests = 0;
   int fails = 0;
   int lat;
   int busy_cycles;

   seq_muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .op(op),
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .result_hi(result_hi),
      .result_lo(result_lo),
      .div_by_zero(div_by_zero),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one request, scrambles the inputs after acceptance, then waits (bounded) for done.
   task automatic do_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        output int latency, output int nbusy);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      op    = ~o;
      a     = ~x;
      b     = ~y;
      latency = 0;
      nbusy   = 0;
      while (!done && latency < 50) begin
         if (busy) nbusy++;
         @(negedge clk);
         latency++;
      end
   endtask

   task automatic check_result(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input logic [15:0] exp,
                               input logic exp_dbz, input logic exp_ill, input int exp_lat);
      do_op(o, x, y, lat, busy_cycles);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " busy"}, busy_cycles, exp_lat);
      check({tag, " result"}, {result_hi, result_lo}, exp);
      check({tag, " flags"}, {div_by_zero, illegal_op}, {exp_dbz, exp_ill});
      @(negedge clk);
      check({tag, " done pulse"}, {done, busy}, 2'b00);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset outputs", {busy, done, result_hi, result_lo, div_by_zero, illegal_op}, '0);
      rst = 1'b0;

      check_result("smul -3*5", 2'b00, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 1'b0, WIDTH);
      repeat (3) @(negedge clk);
      check("idle hold", {result_hi, result_lo, busy, done}, {16'hFFF1, 2'b00});
      check_result("smul 5*-3", 2'b00, 8'h05, 8'hFD, 16'hFFF1, 1'b0, 1'b0, WIDTH);
      check_result("smul -128*-128", 2'b00, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, WIDTH);
      check_result("smul -128*127", 2'b00, 8'h80, 8'h7F, 16'hC080, 1'b0, 1'b0, WIDTH);
      check_result("smul 127*127", 2'b00, 8'h7F, 8'h7F, 16'h3F01, 1'b0, 1'b0, WIDTH);
      check_result("umul 255*255", 2'b01, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, WIDTH);
      check_result("umul 0*195", 2'b01, 8'h00, 8'hC3, 16'h0000, 1'b0, 1'b0, WIDTH);
      check_result("div by zero", 2'b10, 8'h55, 8'h00, 16'h55FF, 1'b1, 1'b0, 0);
      check_result("illegal op", 2'b11, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b1, 0);
      check_result("div 5/9", 2'b10, 8'd5, 8'd9, {8'd5, 8'd0}, 1'b0, 1'b0, WIDTH);
      check_result("div 200/7", 2'b10, 8'd200, 8'd7, {8'd4, 8'd28}, 1'b0, 1'b0, WIDTH);

      // Reset in the middle of a multiply, with an ignored start pulse before it.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      a     = 8'h11;
      b     = 8'h22;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      a     = 8'h33;
      b     = 8'h44;
      @(negedge clk);
      start = 1'b0;
      check("start ignored in calc", {busy, done}, 2'b10);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid-calc reset", {busy, done, result_hi, result_lo, div_by_zero, illegal_op}, '0);
      rst = 1'b0;
      @(negedge clk);
      check("idle after reset", {busy, done}, 2'b00);
      check_result("post-reset umul", 2'b01, 8'h0F, 8'h11, 16'h00FF, 1'b0, 1'b0, WIDTH);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
